lsu_mem_if: RTL
===============

# lsu_mem_if

Parametrised load/store unit between the execute stage and a ready/valid data-memory port. It is the multi-cycle successor to the single-cycle RAM access path. It takes one load or store request at a time and aligns store data into byte lanes with strobes. It extracts and zero/sign-extends load data, and flags misaligned or unsupported accesses without touching memory.

## Interface
Parameters:
- XLEN, 64, register/data width; 32 or 64.
- ADDR_W, 64, address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request offered.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  XLEN  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse; no backpressure.
- resp_err  out  1  misaligned or unsupported size; valid with resp_valid.
- resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  req_addr with the low log2(XLEN/8) bits cleared.
- mem_wdata  out  XLEN  store data shifted into lanes.
- mem_wstrb  out  XLEN/8  byte enables; 0 on loads.
- mem_rvalid  in  1  load data returned.
- mem_rdata  in  XLEN  full aligned bus word.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields.
  - If the access is misaligned (addr mod 2^size ≠ 0) or size=3 with XLEN=32: go to RESP with err=1.
  - Otherwise go to REQ.
- REQ:
  - mem_req_valid=1; mem_* outputs are held stable until mem_req_ready.
  - On the handshake, a store goes to RESP and a load goes to WAIT.
- WAIT: on mem_rvalid, capture the extracted/extended data and go to RESP.
- RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Store lanes:
  - off = addr[log2(XLEN/8)-1:0].
  - wdata is shifted left by off*8.
  - wstrb = ((1<<(1<<size))-1) << off.
- Load extract:
  - Take (mem_rdata >> off*8), masked to 8<<size bits.
  - Fill upper bits with 0 if req_unsigned, otherwise with the MSB of the field.
  - A dword with XLEN=64 passes through unchanged.
- mem_rvalid is ignored outside WAIT; a stale response after reset must not reach resp_*.
- req_valid is ignored outside IDLE.

## Timing
- Reset values:
  - state=IDLE, req_ready=1.
  - mem_req_valid=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0.
  - resp_valid=0, resp_err=0, resp_rdata=0.
- Store latency: accept at cycle t; mem_req_valid at t+1; with mem_req_ready at t+1, resp_valid at t+2.
- Load latency: as for stores, with mem_rvalid at the earliest t+2 and resp_valid at t+3.
- Error latency: resp_valid at t+1 with no memory request.
- Memory stalls (mem_req_ready=0 or a late mem_rvalid) extend REQ or WAIT without limit.
- rst mid-transaction returns to IDLE on the next edge, drops mem_req_valid, and suppresses resp_valid.
- Back-to-back: the next request can be accepted in the cycle after RESP, since IDLE has req_ready=1.

## Structure
- Package lsu_pkg holds:
  - size encodings SZ_B/SZ_H/SZ_W/SZ_D;
  - state enum;
  - function size_bytes(size).
- Sub-module lsu_align, purely combinational:
  - store path: lane shift and wstrb;
  - load path: extract and extend.
  - lsu_mem_if instantiates it and contains only the FSM and registers.

## Test plan
- Store byte, XLEN=64, addr=0x1003, wdata=0xAB, ready immediate -> mem_addr=0x1000, wstrb=0x08, mem_wdata=0x00000000AB000000, resp_valid at t+2, err=0.
- Signed load half, addr=0x2006, mem_rdata=0x8001_0000_0000_0000 -> resp_rdata=0xFFFF_FFFF_FFFF_8001; the same load with req_unsigned=1 -> 0x8001.
- Load word at addr=0x2002 -> resp_err=1, resp_valid at t+1, no mem_req_valid pulse.
- mem_req_ready held low for 5 cycles during a store -> mem_* outputs stable throughout; resp_valid one cycle after the handshake.
- Load with mem_rvalid delayed 4 cycles, plus a spurious mem_rvalid in IDLE -> only the real response is reported.
- rst asserted while in WAIT, then mem_rvalid arrives -> IDLE, req_ready=1, no resp_valid; XLEN=32 dword request -> resp_err=1.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP
  } lsu_state_e;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: store data/strobe placement and load extract/extend.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [1:0]               size_i,
  input  logic                     unsigned_i,
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  logic [XLEN-1:0]          wdata_i,
  input  logic [XLEN-1:0]          rdata_i,
  output logic [XLEN-1:0]          wdata_o,
  output logic [XLEN/8-1:0]        wstrb_o,
  output logic [XLEN-1:0]          rdata_o
);

  localparam int NB = XLEN / 8;
  localparam logic [XLEN-1:0] ONE = {{(XLEN-1){1'b0}}, 1'b1};

  logic [15:0]     lane_mask;
  logic [6:0]      nbits;
  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] fmask;
  logic [XLEN-1:0] sign_fill;
  logic            msb;

  always_comb begin
    lane_mask = (16'd1 << size_bytes(size_i)) - 16'd1;
    wstrb_o   = lane_mask[NB-1:0] << off_i;
    wdata_o   = wdata_i << {off_i, 3'b000};

    // A field as wide as the bus wraps the shift to zero, so the mask becomes all ones.
    nbits     = 7'd8 << size_i;
    shifted   = rdata_i >> {off_i, 3'b000};
    fmask     = (ONE << nbits) - ONE;
    msb       = |(shifted & (fmask ^ (fmask >> 1)));
    sign_fill = (!unsigned_i && msb) ? ~fmask : '0;
    rdata_o   = (shifted & fmask) | sign_fill;
  end

endmodule

// File: rtl/lsu_mem_if.sv
// Multi-cycle load/store unit: one request at a time, ready/valid memory port.
module lsu_mem_if
  import lsu_pkg::*;
#(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_unsigned,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  output logic                resp_valid,
  output logic                resp_err,
  output logic [XLEN-1:0]     resp_rdata,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  output logic [XLEN/8-1:0]   mem_wstrb,
  input  logic                mem_rvalid,
  input  logic [XLEN-1:0]     mem_rdata,
  output lsu_state_e          dbg_state_o
);

  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both
  // high; the request side holds its payload stable from valid until that edge.
  // resp_valid and mem_rvalid are single-cycle pulses with no ready.

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;

  logic [XLEN-1:0]   st_data;
  logic [NB-1:0]     st_strb;
  logic [XLEN-1:0]   ld_data;
  logic              req_bad;

  assign req_bad = ((req_addr[2:0] & 3'(size_bytes(req_size) - 4'd1)) != 3'b000)
                 || ((XLEN == 32) && (req_size == SZ_D));

  lsu_align #(.XLEN(XLEN)) u_align (
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .off_i      (addr_q[OFF_W-1:0]),
    .wdata_i    (wdata_q),
    .rdata_i    (mem_rdata),
    .wdata_o    (st_data),
    .wstrb_o    (st_strb),
    .rdata_o    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    err_d         = err_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    rdata_d       = rdata_q;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    resp_valid    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size;
          uns_d   = req_unsigned;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          err_d   = req_bad;
          state_d = req_bad ? ST_RESP : ST_REQ;
        end
      end
      ST_REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = we_q ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          rdata_d = ld_data;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign mem_we      = mem_req_valid & we_q;
  assign mem_wstrb   = (mem_req_valid && we_q) ? st_strb : '0;
  assign mem_addr    = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign mem_wdata   = st_data;
  assign resp_err    = resp_valid & err_q;
  assign resp_rdata  = resp_valid ? rdata_q : '0;
  assign dbg_state_o = state_q;

endmodule
